cdc_channel_arbiter: RTL and testbench
======================================

Name: cdc_channel_arbiter

Overview:
Shares the single 12-bit fast-to-slow crossing channel between NUM_REQ fast-domain sample sources. Round-robin arbitration selects one source. Its sample is registered onto the crossing input and held stable for HOLD_CYCLES fast cycles, so the slow domain captures it intact. The block sits entirely in the fast domain, directly upstream of the fast-to-slow synchronizer, and tags each slot with the source index.

Parameters:
NUM_REQ, 4, number of requesting sources (2..8).
DATA_W, 12, sample width; must equal the crossing width.
HOLD_CYCLES, 8, fast cycles each granted sample is held. Must be >= 2 and >= (fast/slow ratio + 3).
TAG_W, $clog2(NUM_REQ), width of the source tag.

Ports:
FAST_clk  in  1  fast clock; all logic on posedge.
reset  in  1  synchronous, active-high reset.
req  in  NUM_REQ  per-source request level; held high until the matching ack.
req_data  in  NUM_REQ*DATA_W  packed samples; source i occupies bits [i*DATA_W +: DATA_W]; held stable while req[i] is high.
ack  out  NUM_REQ  one-hot, one-cycle pulse: source's sample has been taken.
xfer_data  out  DATA_W  sample driven into the crossing channel.
xfer_tag  out  TAG_W  index of the source owning xfer_data.
xfer_valid  out  1  high while the current slot holds a granted sample.
busy  out  1  high in HOLD state.

Behaviour:
- Reset is sampled on posedge FAST_clk. Reset values: xfer_data=0, xfer_tag=0, xfer_valid=0, ack=0, busy=0, state=IDLE, hold counter=0, last-grant pointer=NUM_REQ-1 (so source 0 has first priority).
- Reset asserted mid-slot aborts the slot. Outputs go to reset values at that edge. No ack is issued for an in-flight request.
- States:
  - IDLE: no active slot; xfer_data/xfer_tag retain the last values; xfer_valid=0.
  - HOLD: slot active; xfer_valid=1.
- Arbitration is combinational over the registered req. The winner is the first set bit searching upward, with wrap, starting at (last_grant+1) mod NUM_REQ.
- Grant edge: taken in IDLE with |req=1, or in HOLD with counter==0 and |req=1. At that edge:
  - xfer_data <= winner's req_data slice
  - xfer_tag <= winner
  - ack <= onehot(winner)
  - last_grant <= winner
  - counter <= HOLD_CYCLES-1
  - state <= HOLD
- Latency: req[i] high before edge N (IDLE, i wins) gives ack[i] and new xfer_data visible after edge N. ack is high for exactly one cycle. The source may drop req or change data from the cycle after ack.
- HOLD: the counter decrements by 1 each cycle. xfer_data and xfer_tag must not change during a slot.
- Expiry with counter==0:
  - |req=1: back-to-back grant, no idle gap; xfer_valid stays 1.
  - |req=0: state <= IDLE, xfer_valid <= 0.
- A source whose ack pulse is high in the same cycle as a back-to-back grant edge is excluded from that arbitration. This prevents a stale req being double-granted.
- Requests arriving during HOLD wait. They are not lost, because requesters hold req until ack.
- Slot period is exactly HOLD_CYCLES cycles. Under continuous requests from all sources, each source is granted once per NUM_REQ*HOLD_CYCLES cycles (fairness bound).
- Single requester repeatedly requesting is granted every HOLD_CYCLES cycles.
- ack is never issued to a source whose req is low. At most one ack bit is high in any cycle.
- Width: req_data slices are taken unmodified; no arithmetic on data. The counter width is $clog2(HOLD_CYCLES).

Decomposition:
- Shared package cdc_arb_pkg holds:
  - DATA_W default
  - NUM_REQ default
  - state enum {IDLE, HOLD}
  - function onehot(idx)
- One sub-module, rr_pick: combinational rotate-priority encoder.
  - Inputs: req vector, last-grant pointer, ack mask.
  - Outputs: winner index and any-valid.
- The top holds the FSM, hold counter and output registers.

Test Plan:
1. Reset then idle. Hold reset 3 cycles, req=0 for 20 cycles -> all outputs 0, busy=0, xfer_valid=0 throughout.
2. Single grant. req=0001, req_data[0]=0xABC -> ack=0001 for 1 cycle after next edge; xfer_data=0xABC, tag=0, xfer_valid=1 for exactly 8 cycles, then IDLE with xfer_data still 0xABC.
3. Round-robin fairness. req=1111 held continuously, data_i=0x100+i -> tags sequence 0,1,2,3,0,...; each slot 8 cycles; no idle gaps; each ack once per 32 cycles.
4. Rotating priority after a grant. Grant source 2, then req=0101 at expiry -> source 0 next (wrap from pointer 2 skips 3), then source 2.
5. Reset mid-slot. Reset at hold-counter=4 with req=0010 pending -> next cycle all outputs 0 and no ack. After release, source 1 is granted with a full 8-cycle slot.
6. Data stability. Change req_data[1] every cycle during source 1's slot -> xfer_data equals the value sampled at the grant edge for all 8 cycles; a checker asserts no mid-slot change.

Source files
------------

// File: rtl/cdc_channel_arbiter_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// cdc_arb_pkg : shared defaults, FSM state type and one-hot helper
// rev 1.0
// ------------------------------------------------------------------
package cdc_arb_pkg;

  localparam int CDC_NUM_REQ = 4;
  localparam int CDC_DATA_W  = 12;
  localparam int MAX_REQ     = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  function automatic logic [MAX_REQ-1:0] onehot(input logic [2:0] idx);
    logic [MAX_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cdc_channel_arbiter_if.sv
`default_nettype none
// ------------------------------------------------------------------
// cdc_channel_arbiter_if : source requests and crossing-channel slot
// rev 1.0
// ------------------------------------------------------------------
interface cdc_channel_arbiter_if
  import cdc_arb_pkg::*;
#(
  parameter int NUM_REQ = CDC_NUM_REQ,
  parameter int DATA_W  = CDC_DATA_W,
  parameter int TAG_W   = $clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        ack;
  logic [DATA_W-1:0]         xfer_data;
  logic [TAG_W-1:0]          xfer_tag;
  logic                      xfer_valid;
  logic                      busy;

  modport master (
    output req, req_data,
    input  ack, xfer_data, xfer_tag, xfer_valid, busy
  );

  modport slave (
    input  req, req_data,
    output ack, xfer_data, xfer_tag, xfer_valid, busy
  );

endinterface
`default_nettype wire

// File: rtl/cdc_channel_arbiter_rr_pick.sv
`default_nettype none
// ------------------------------------------------------------------
// rr_pick : rotate-priority encoder, search starts after last grant
// rev 1.0
// ------------------------------------------------------------------
module rr_pick
  import cdc_arb_pkg::*;
#(
  parameter int NUM_REQ = CDC_NUM_REQ,
  parameter int TAG_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [TAG_W-1:0]   last,
  input  logic [NUM_REQ-1:0] mask,
  output logic [TAG_W-1:0]   winner,
  output logic               any
);

  logic [NUM_REQ-1:0] eligible;
  logic [TAG_W-1:0]   idx;

  assign eligible = req & ~mask;

  // Walk from the farthest candidate back to the nearest so the
  // nearest eligible source after the pointer is written last.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = TAG_W'((int'(last) + k) % NUM_REQ);
      if (eligible[idx]) begin
        winner = idx;
        any    = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cdc_channel_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// cdc_channel_arbiter : round-robin sharing of the fast-to-slow crossing
// rev 1.0
// ------------------------------------------------------------------
module cdc_channel_arbiter
  import cdc_arb_pkg::*;
#(
  parameter int NUM_REQ     = CDC_NUM_REQ,
  parameter int DATA_W      = CDC_DATA_W,
  parameter int HOLD_CYCLES = 8,
  parameter int TAG_W       = $clog2(NUM_REQ)
) (
  input  logic                 FAST_clk,
  input  logic                 reset,
  cdc_channel_arbiter_if.slave bus
);

  localparam int CNT_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;

  arb_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [TAG_W-1:0]    last_q;
  logic [TAG_W-1:0]    winner;
  logic                any_req;
  logic                grant;
  logic [DATA_W-1:0]   data_q;
  logic [TAG_W-1:0]    tag_q;
  logic                valid_q;
  logic [NUM_REQ-1:0]  ack_q;

  // A source still seeing its ack pulse is masked so its stale req
  // cannot win a back-to-back slot.
  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .TAG_W   (TAG_W)
  ) u_pick (
    .req    (bus.req),
    .last   (last_q),
    .mask   (ack_q),
    .winner (winner),
    .any    (any_req)
  );

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) grant = 1'b1;
      end
      HOLD: begin
        if (cnt_q == '0) begin
          if (any_req) grant = 1'b1;
          else         state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (grant) state_d = HOLD;
  end

  always_ff @(posedge FAST_clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= TAG_W'(NUM_REQ - 1);
      data_q  <= '0;
      tag_q   <= '0;
      valid_q <= 1'b0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= '0;
      if (grant) begin
        data_q  <= bus.req_data[int'(winner)*DATA_W +: DATA_W];
        tag_q   <= winner;
        ack_q   <= NUM_REQ'(onehot(3'(winner)));
        last_q  <= winner;
        cnt_q   <= CNT_W'(HOLD_CYCLES - 1);
        valid_q <= 1'b1;
      end else if (state_q == HOLD) begin
        if (cnt_q != '0) cnt_q   <= cnt_q - CNT_W'(1);
        else             valid_q <= 1'b0;
      end
    end
  end

  assign bus.ack        = ack_q;
  assign bus.xfer_data  = data_q;
  assign bus.xfer_tag   = tag_q;
  assign bus.xfer_valid = valid_q;
  assign bus.busy       = (state_q == HOLD);

endmodule
`default_nettype wire

// File: tb/tb_cdc_channel_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_cdc_channel_arbiter : directed vector table plus corner sequences
// rev 1.0
// ------------------------------------------------------------------
module tb_cdc_channel_arbiter;

  logic clk;
  logic reset;

  cdc_channel_arbiter_if #(.NUM_REQ(4), .DATA_W(12), .TAG_W(2)) bus ();

  cdc_channel_arbiter #(
    .NUM_REQ     (4),
    .DATA_W      (12),
    .HOLD_CYCLES (8),
    .TAG_W       (2)
  ) dut (
    .FAST_clk (clk),
    .reset    (reset),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [47:0] data;
    logic [3:0]  ack;
    logic [11:0] xd;
    logic [1:0]  tag;
    logic        valid;
  } vec_t;

  vec_t vq[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic mon_en = 1'b0;
  logic [3:0]  req_prev;
  logic [11:0] slot_d;
  logic        slot_ok = 1'b0;

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic rst, input logic [3:0] req, input logic [47:0] d,
                     input logic [3:0] a, input logic [11:0] xd, input logic [1:0] t,
                     input logic v);
    vec_t e;
    e.rst = rst; e.req = req; e.data = d; e.ack = a; e.xd = xd; e.tag = t; e.valid = v;
    vq.push_back(e);
  endtask

  task automatic chk_out(input string nm, input logic [3:0] a, input logic [11:0] xd,
                         input logic [1:0] t, input logic v);
    chk({nm, "_ack"},   48'(bus.ack),        48'(a));
    chk({nm, "_data"},  48'(bus.xfer_data),  48'(xd));
    chk({nm, "_tag"},   48'(bus.xfer_tag),   48'(t));
    chk({nm, "_valid"}, 48'(bus.xfer_valid), 48'(v));
    chk({nm, "_busy"},  48'(bus.busy),       48'(v));
  endtask

  // Independent monitors: slot data frozen after grant, ack one-hot and only to requesters.
  always @(posedge clk) req_prev <= bus.req;

  always @(negedge clk) begin
    if (mon_en) begin
      if (!bus.xfer_valid) slot_ok = 1'b0;
      else if (bus.ack != 4'b0) begin
        slot_d  = bus.xfer_data;
        slot_ok = 1'b1;
      end else if (slot_ok) chk("slot_stable", 48'(bus.xfer_data), 48'(slot_d));
      chk("ack_legal", 48'({$onehot0(bus.ack), ((bus.ack & ~req_prev) == 4'b0)}), 48'(2'b11));
    end
  end

  initial begin
    logic [47:0] d0, da, db, drr, d5;
    reset        = 1'b1;
    bus.req      = 4'b0;
    bus.req_data = 48'b0;

    // reset then idle
    for (int i = 0; i < 3; i++)  add(1'b1, 4'b0, 48'b0, 4'b0, 12'h0, 2'd0, 1'b0);
    for (int i = 0; i < 20; i++) add(1'b0, 4'b0, 48'b0, 4'b0, 12'h0, 2'd0, 1'b0);
    // single grant of source 0, eight-cycle slot, then idle retaining data
    d0 = {12'h0, 12'h0, 12'h0, 12'hABC};
    add(1'b0, 4'b0001, d0, 4'b0001, 12'hABC, 2'd0, 1'b1);
    for (int i = 0; i < 7; i++) add(1'b0, 4'b0, d0, 4'b0, 12'hABC, 2'd0, 1'b1);
    for (int i = 0; i < 2; i++) add(1'b0, 4'b0, d0, 4'b0, 12'hABC, 2'd0, 1'b0);
    // rotating priority: 2, then 0101 at expiry gives 0, then 2
    da = {12'h0, 12'h2AA, 12'h0, 12'h0};
    db = {12'h0, 12'h2BB, 12'h0, 12'h0A5};
    add(1'b0, 4'b0100, da, 4'b0100, 12'h2AA, 2'd2, 1'b1);
    for (int i = 0; i < 6; i++) add(1'b0, 4'b0, da, 4'b0, 12'h2AA, 2'd2, 1'b1);
    add(1'b0, 4'b0101, db, 4'b0,    12'h2AA, 2'd2, 1'b1);
    add(1'b0, 4'b0101, db, 4'b0001, 12'h0A5, 2'd0, 1'b1);
    for (int i = 0; i < 7; i++) add(1'b0, 4'b0100, db, 4'b0, 12'h0A5, 2'd0, 1'b1);
    add(1'b0, 4'b0100, db, 4'b0100, 12'h2BB, 2'd2, 1'b1);
    for (int i = 0; i < 7; i++) add(1'b0, 4'b0, db, 4'b0, 12'h2BB, 2'd2, 1'b1);
    add(1'b0, 4'b0, db, 4'b0, 12'h2BB, 2'd2, 1'b0);

    @(negedge clk);
    foreach (vq[i]) begin
      reset        = vq[i].rst;
      bus.req      = vq[i].req;
      bus.req_data = vq[i].data;
      @(negedge clk);
      mon_en = 1'b1;
      chk_out($sformatf("v%0d", i), vq[i].ack, vq[i].xd, vq[i].tag, vq[i].valid);
    end

    // round-robin with all sources requesting continuously
    reset   = 1'b1;
    bus.req = 4'b0;
    @(negedge clk);
    reset        = 1'b0;
    bus.req      = 4'b1111;
    drr          = {12'h103, 12'h102, 12'h101, 12'h100};
    bus.req_data = drr;
    for (int s = 0; s < 12; s++) begin
      for (int c = 0; c < 8; c++) begin
        logic [3:0] ea;
        ea = (c == 0) ? (4'b0001 << (s % 4)) : 4'b0;
        @(negedge clk);
        chk_out($sformatf("rr_s%0d_c%0d", s, c), ea, 12'h100 + 12'(s % 4), 2'(s % 4), 1'b1);
      end
    end
    bus.req = 4'b0;
    @(negedge clk);
    chk_out("rr_end", 4'b0, 12'h103, 2'd3, 1'b0);

    // reset mid-slot with source 1 pending; then data stability under changing input
    d5           = {12'h3D3, 12'h0, 12'h1C1, 12'h0};
    bus.req_data = d5;
    bus.req      = 4'b1000;
    @(negedge clk);
    chk_out("mr_grant3", 4'b1000, 12'h3D3, 2'd3, 1'b1);
    bus.req = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_out($sformatf("mr_wait%0d", c), 4'b0, 12'h3D3, 2'd3, 1'b1);
    end
    reset = 1'b1;
    @(negedge clk);
    chk_out("mr_reset", 4'b0, 12'h0, 2'd0, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk_out("mr_grant1", 4'b0010, 12'h1C1, 2'd1, 1'b1);
    bus.req = 4'b0;
    for (int c = 1; c < 8; c++) begin
      bus.req_data[23:12] = 12'($urandom);
      @(negedge clk);
      chk_out($sformatf("ds_c%0d", c), 4'b0, 12'h1C1, 2'd1, 1'b1);
    end
    bus.req_data[23:12] = 12'($urandom);
    @(negedge clk);
    chk_out("ds_idle", 4'b0, 12'h1C1, 2'd1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
